// File: rtl/synth_pkg.sv
// Shared defaults, sample typedef and clog2 helper for the sample accumulator slice.
package synth_pkg;

    localparam int unsigned DEF_SUB_WIDTH      = 16;
    localparam int unsigned DEF_OUT_WIDTH      = 16;
    localparam int unsigned DEF_NUM_SUBSAMPLES = 16;
    localparam int unsigned DEF_OUT_SHIFT      = 4;

    typedef logic signed [15:0] sample_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_scaler.sv
// Arithmetic right shift of the final sum, then fit to OUT_WIDTH.
// SAMPLE_ACCUMULATOR_SATURATE_EN selects clamping; otherwise the low bits wrap.
module sample_scaler
    import synth_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = DEF_SUB_WIDTH + 4,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic [ACC_WIDTH-1:0] i_Sum,
    output logic [OUT_WIDTH-1:0] o_Scaled
);

    // Extended width keeps the range checks valid even if OUT_WIDTH exceeds ACC_WIDTH.
    localparam int unsigned EXT_WIDTH = ACC_WIDTH + OUT_WIDTH;

    logic signed [EXT_WIDTH-1:0] w_Ext;
    logic signed [EXT_WIDTH-1:0] w_Shifted;

    assign w_Ext     = EXT_WIDTH'(signed'(i_Sum));
    assign w_Shifted = w_Ext >>> OUT_SHIFT;

`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
    localparam logic signed [EXT_WIDTH-1:0] MAX_VAL =
        {{(EXT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_WIDTH-1:0] MIN_VAL =
        {{(EXT_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        o_Scaled = OUT_WIDTH'(w_Shifted);
        if (w_Shifted > MAX_VAL) begin
            o_Scaled = OUT_WIDTH'(MAX_VAL);
        end else if (w_Shifted < MIN_VAL) begin
            o_Scaled = OUT_WIDTH'(MIN_VAL);
        end
    end
`else
    assign o_Scaled = OUT_WIDTH'(w_Shifted);
`endif

endmodule

// File: rtl/sample_accumulator.sv
// Sums NUM_SUBSAMPLES signed subsamples into one scaled output sample with a valid/ready
// output register and sticky overrun flag. Fit mode set by SAMPLE_ACCUMULATOR_SATURATE_EN.
module sample_accumulator
    import synth_pkg::*;
#(
    parameter int unsigned SUB_WIDTH      = DEF_SUB_WIDTH,
    parameter int unsigned OUT_WIDTH      = DEF_OUT_WIDTH,
    parameter int unsigned NUM_SUBSAMPLES = DEF_NUM_SUBSAMPLES,
    parameter int unsigned OUT_SHIFT      = DEF_OUT_SHIFT
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset,
    input  logic                                i_SubsampleValid,
    input  logic [SUB_WIDTH-1:0]                i_Subsample,
    output logic                                o_SampleValid,
    output logic [OUT_WIDTH-1:0]                o_Sample,
    input  logic                                i_SampleReady,
    output logic                                o_Overrun,
    input  logic                                i_ClearOverrun,
    output logic [clog2(NUM_SUBSAMPLES)-1:0]    o_SubsampleCount
);

    localparam int unsigned CNT_WIDTH = clog2(NUM_SUBSAMPLES);
    localparam int unsigned ACC_WIDTH = SUB_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(NUM_SUBSAMPLES - 1);

    logic signed [ACC_WIDTH-1:0] r_Acc;
    logic [CNT_WIDTH-1:0]        r_Count;
    logic [OUT_WIDTH-1:0]        r_Sample;
    logic                        r_SampleValid;
    logic                        r_Overrun;

    logic signed [ACC_WIDTH-1:0] w_SubExt;
    logic signed [ACC_WIDTH-1:0] w_Sum;
    logic [OUT_WIDTH-1:0]        w_Scaled;
    logic                        w_Last;
    logic                        w_Handshake;

    assign w_SubExt    = ACC_WIDTH'(signed'(i_Subsample));
    assign w_Sum       = r_Acc + w_SubExt;
    assign w_Last      = i_SubsampleValid && (r_Count == LAST_COUNT);
    assign w_Handshake = r_SampleValid && i_SampleReady;

    sample_scaler #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_scaler (
        .i_Sum    (w_Sum),
        .o_Scaled (w_Scaled)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Acc         <= '0;
            r_Count       <= '0;
            r_Sample      <= '0;
            r_SampleValid <= 1'b0;
            r_Overrun     <= 1'b0;
        end else begin
            if (w_Last) begin
                r_Acc   <= '0;
                r_Count <= '0;
            end else if (i_SubsampleValid) begin
                r_Acc   <= w_Sum;
                r_Count <= r_Count + CNT_WIDTH'(1);
            end

            // A load wins over a handshake so a coinciding completion keeps valid high.
            if (w_Last) begin
                r_Sample      <= w_Scaled;
                r_SampleValid <= 1'b1;
            end else if (w_Handshake) begin
                r_SampleValid <= 1'b0;
            end

            if (i_ClearOverrun) begin
                r_Overrun <= 1'b0;
            end else if (w_Last && r_SampleValid && !i_SampleReady) begin
                r_Overrun <= 1'b1;
            end
        end
    end

    assign o_SampleValid    = r_SampleValid;
    assign o_Sample         = r_Sample;
    assign o_Overrun        = r_Overrun;
    assign o_SubsampleCount = r_Count;

endmodule

// File: tb/tb_sample_accumulator.sv
// Scoreboard bench for sample_accumulator: default instance plus an OUT_SHIFT=0 instance.
module tb_sample_accumulator;
    import synth_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sv, rdy, clr;
    logic [15:0] sub;
    logic        ovalid, oovr;
    logic [15:0] osample;
    logic [3:0]  ocnt;

    logic        rst0, sv0, rdy0, clr0;
    logic [15:0] sub0;
    logic        ovalid0, oovr0;
    logic [15:0] osample0;
    logic [3:0]  ocnt0;

    sample_accumulator u_dut (
        .i_Clock          (clk),
        .i_Reset          (rst),
        .i_SubsampleValid (sv),
        .i_Subsample      (sub),
        .o_SampleValid    (ovalid),
        .o_Sample         (osample),
        .i_SampleReady    (rdy),
        .o_Overrun        (oovr),
        .i_ClearOverrun   (clr),
        .o_SubsampleCount (ocnt)
    );

    sample_accumulator #(.OUT_SHIFT(0)) u_dut0 (
        .i_Clock          (clk),
        .i_Reset          (rst0),
        .i_SubsampleValid (sv0),
        .i_Subsample      (sub0),
        .o_SampleValid    (ovalid0),
        .o_Sample         (osample0),
        .i_SampleReady    (rdy0),
        .o_Overrun        (oovr0),
        .i_ClearOverrun   (clr0),
        .o_SubsampleCount (ocnt0)
    );

    sample_t exp_q[$];
    sample_t exp0_q[$];
    int passes = 0;
    int total  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act == exp) passes = passes + 1;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitors: a sample is consumed on the edge following a negedge where valid & ready.
    always @(negedge clk) begin
        if (!rst && ovalid && rdy) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                $display("FAIL unexpected_sample: got %0d, expected none", $signed(osample));
            end else begin
                check("sample", $signed(osample), exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst0 && ovalid0 && rdy0) begin
            if (exp0_q.size() == 0) begin
                total = total + 1;
                $display("FAIL unexpected_sample0: got %0d, expected none", $signed(osample0));
            end else begin
                check("sample0", $signed(osample0), exp0_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        sv  = 1'b1;
        sub = d;
        tick();
        sv  = 1'b0;
    endtask

    task automatic send0(input logic [15:0] d);
        sv0  = 1'b1;
        sub0 = d;
        tick();
        sv0  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            total = total + 1;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic drain0();
        for (int i = 0; i < 40 && exp0_q.size() != 0; i++) tick();
        if (exp0_q.size() != 0) begin
            total = total + 1;
            $display("FAIL drain0_timeout: got %0d pending, expected 0", exp0_q.size());
            exp0_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sv = 1'b0; sub = '0; rdy = 1'b1; clr = 1'b0;
        rst0 = 1'b1; sv0 = 1'b0; sub0 = '0; rdy0 = 1'b1; clr0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        rst0 = 1'b0;
        check("reset_valid", ovalid, 0);
        check("reset_sample", osample, 0);
        check("reset_overrun", oovr, 0);
        check("reset_count", ocnt, 0);

        // 16 x +1000 back-to-back
        exp_q.push_back(sample_t'(1000));
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("count_before_last", ocnt, 15);
            send(16'd1000);
        end
        check("valid_after_last", ovalid, 1);
        check("count_after_last", ocnt, 0);
        drain();
        check("valid_after_handshake", ovalid, 0);
        check("sample_held", $signed(osample), 1000);

        // 16 x -1 with gaps
        exp_q.push_back(sample_t'(-1));
        for (int i = 0; i < 16; i++) begin
            send(16'hFFFF);
            if (i == 5) begin
                tick();
                tick();
                check("count_hold_gap", ocnt, 6);
            end
        end
        drain();

        // OUT_SHIFT=0, 16 x 32767
`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
        exp0_q.push_back(sample_t'(32767));
`else
        exp0_q.push_back(sample_t'(-16));
`endif
        for (int i = 0; i < 16; i++) send0(16'd32767);
        drain0();

        // Overrun: 100 then 200 without ready
        rdy = 1'b0;
        for (int i = 0; i < 16; i++) send(16'd100);
        check("ovr_first_valid", ovalid, 1);
        check("ovr_first_flag", oovr, 0);
        check("ovr_first_sample", $signed(osample), 100);
        for (int i = 0; i < 16; i++) send(16'd200);
        check("ovr_sample", $signed(osample), 200);
        check("ovr_set", oovr, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovr_cleared", oovr, 0);
        // Clear coinciding with a fresh overrun
        for (int i = 0; i < 16; i++) begin
            if (i == 15) clr = 1'b1;
            send(16'd50);
            clr = 1'b0;
        end
        check("ovr_clear_priority", oovr, 0);
        exp_q.push_back(sample_t'(50));
        rdy = 1'b1;
        drain();

        // Load coinciding with a handshake
        rdy = 1'b0;
        for (int i = 0; i < 16; i++) send(16'd300);
        check("coinc_first_valid", ovalid, 1);
        exp_q.push_back(sample_t'(300));
        exp_q.push_back(sample_t'(400));
        for (int i = 0; i < 16; i++) begin
            if (i == 15) rdy = 1'b1;
            send(16'd400);
        end
        check("coinc_valid", ovalid, 1);
        check("coinc_overrun", oovr, 0);
        drain();

        // Partial sample discarded by reset (reset wins over a valid subsample)
        for (int i = 0; i < 7; i++) send(16'd500);
        check("partial_count", ocnt, 7);
        rst = 1'b1;
        sv  = 1'b1;
        sub = 16'd500;
        tick();
        rst = 1'b0;
        sv  = 1'b0;
        check("rst2_count", ocnt, 0);
        check("rst2_valid", ovalid, 0);
        check("rst2_sample", osample, 0);
        check("rst2_overrun", oovr, 0);
        exp_q.push_back(sample_t'(10));
        for (int i = 0; i < 16; i++) send(16'd10);
        drain();
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
